// File: rtl/daq_arb_pkg.sv
// rtl/daq_arb_pkg.sv - shared types and helpers for the DAQ channel arbiter
package daq_arb_pkg;

  typedef enum logic [1:0] {
    ARB_RR       = 2'd0,
    ARB_PRIO     = 2'd1,
    ARB_WEIGHTED = 2'd2,
    ARB_DYNAMIC  = 2'd3
  } arb_mode_e;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Age counters are wide enough for the largest allowed starvation limit.
  localparam int AGE_WIDTH = 16;

  // Default channel-index width; a two-channel arbiter still needs one bit.
  function automatic int daq_chan_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/daq_rr_picker.sv
// rtl/daq_rr_picker.sv - rotating first-one finder starting after a pointer
module daq_rr_picker
  import daq_arb_pkg::*;
#(
  parameter int NUM_CHANNELS  = 16,
  parameter int CHANNEL_WIDTH = daq_chan_width(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0]  i_mask,
  input  logic [CHANNEL_WIDTH-1:0] i_ptr,
  output logic                     o_found,
  output logic [CHANNEL_WIDTH-1:0] o_index
);

  logic [NUM_CHANNELS-1:0]  w_upper;
  logic [CHANNEL_WIDTH-1:0] w_upper_idx;
  logic [CHANNEL_WIDTH-1:0] w_lower_idx;

  // Channels strictly above the pointer are searched before wrapping to the bottom.
  always_comb begin
    w_upper = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_upper[i] = i_mask[i] && (i > int'(i_ptr));
    end
  end

  // Lowest set bit of each half; scanning downward leaves the lowest index last.
  always_comb begin
    w_upper_idx = '0;
    w_lower_idx = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (w_upper[i]) w_upper_idx = CHANNEL_WIDTH'(i);
      if (i_mask[i])  w_lower_idx = CHANNEL_WIDTH'(i);
    end
  end

  assign o_found = |i_mask;
  assign o_index = (|w_upper) ? w_upper_idx : w_lower_idx;

endmodule

// File: rtl/daq_channel_arbiter.sv
// rtl/daq_channel_arbiter.sv - multi-mode DAQ channel arbiter with aging and grant/ack
module daq_channel_arbiter
  import daq_arb_pkg::*;
#(
  parameter int NUM_CHANNELS  = 16,
  parameter int CHANNEL_WIDTH = daq_chan_width(NUM_CHANNELS),
  parameter int PRIO_WIDTH    = 4,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int AGE_LIMIT     = 255
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [1:0]                           i_mode,
  input  logic [NUM_CHANNELS-1:0]              i_channel_enable,
  input  logic [NUM_CHANNELS-1:0]              i_channel_ready,
  input  logic [NUM_CHANNELS-1:0]              i_urgent_mask,
  input  logic [NUM_CHANNELS*PRIO_WIDTH-1:0]   i_priority_flat,
  input  logic [NUM_CHANNELS*WEIGHT_WIDTH-1:0] i_weight_flat,
  input  logic                                 i_adc_busy,
  output logic                                 o_grant_valid,
  output logic [CHANNEL_WIDTH-1:0]             o_grant_channel,
  input  logic                                 i_grant_ack,
  output logic                                 o_starve_flag
);

  arb_state_e               r_state;
  arb_state_e               w_state_next;
  logic [CHANNEL_WIDTH-1:0] r_grant_channel;
  logic                     r_starve_flag;
  logic [CHANNEL_WIDTH-1:0] r_ptr;
  logic [CHANNEL_WIDTH-1:0] r_ptr_pend;
  logic [AGE_WIDTH-1:0]     r_age         [NUM_CHANNELS];
  logic [WEIGHT_WIDTH-1:0]  r_credit      [NUM_CHANNELS];
  logic [WEIGHT_WIDTH-1:0]  r_credit_pend [NUM_CHANNELS];

  arb_mode_e                w_mode;
  logic [NUM_CHANNELS-1:0]  w_elig;
  logic [NUM_CHANNELS-1:0]  w_starved;
  logic [NUM_CHANNELS-1:0]  w_urgent;
  logic [NUM_CHANNELS-1:0]  w_prio_tie;
  logic [NUM_CHANNELS-1:0]  w_wcand_raw;
  logic [NUM_CHANNELS-1:0]  w_wcand;
  logic [NUM_CHANNELS-1:0]  w_credit_tie;
  logic [PRIO_WIDTH-1:0]    w_prio        [NUM_CHANNELS];
  logic [WEIGHT_WIDTH-1:0]  w_weight      [NUM_CHANNELS];
  logic [WEIGHT_WIDTH-1:0]  w_credit_eff  [NUM_CHANNELS];
  logic [WEIGHT_WIDTH-1:0]  w_credit_base [NUM_CHANNELS];
  logic [WEIGHT_WIDTH-1:0]  w_credit_book [NUM_CHANNELS];
  logic [PRIO_WIDTH-1:0]    w_max_prio;
  logic [WEIGHT_WIDTH-1:0]  w_max_credit;
  logic                     w_all_zero;

  logic                     w_starve_found, w_prio_found, w_credit_found;
  logic                     w_urgent_found, w_plain_found;
  logic [CHANNEL_WIDTH-1:0] w_starve_idx, w_prio_idx, w_credit_idx;
  logic [CHANNEL_WIDTH-1:0] w_urgent_idx, w_plain_idx;

  logic [CHANNEL_WIDTH-1:0] w_winner;
  logic                     w_starve_pick;
  logic                     w_use_weighted;
  logic                     w_reload;
  logic                     w_decrement;
  logic                     w_grant_fire;
  logic                     w_ack_fire;

  assign w_mode          = arb_mode_e'(i_mode);
  assign w_urgent        = w_elig & i_urgent_mask;
  assign o_grant_valid   = (r_state == HOLD);
  assign o_grant_channel = r_grant_channel;
  assign o_starve_flag   = r_starve_flag;

  // Per-channel views of the flat buses, eligibility, starvation and zero-credit detection.
  always_comb begin
    w_elig      = i_channel_ready & i_channel_enable;
    w_starved   = '0;
    w_wcand_raw = '0;
    w_all_zero  = 1'b1;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_prio[i]      = i_priority_flat[i*PRIO_WIDTH +: PRIO_WIDTH];
      w_weight[i]    = i_weight_flat[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      w_starved[i]   = w_elig[i] && (r_age[i] >= AGE_WIDTH'(AGE_LIMIT));
      w_wcand_raw[i] = w_elig[i] && (w_weight[i] != '0);
      if (w_elig[i] && (r_credit[i] != '0)) w_all_zero = 1'b0;
    end
  end

  // Highest eligible priority and the set of channels tied at it.
  always_comb begin
    w_max_prio = '0;
    w_prio_tie = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (w_elig[i] && (w_prio[i] > w_max_prio)) w_max_prio = w_prio[i];
    end
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_prio_tie[i] = w_elig[i] && (w_prio[i] == w_max_prio);
    end
  end

  // Weighted candidates: zero-weight channels only compete when nothing else can; an
  // all-zero credit pool is judged as if already reloaded from the weights.
  always_comb begin
    w_wcand      = (|w_wcand_raw) ? w_wcand_raw : w_elig;
    w_max_credit = '0;
    w_credit_tie = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_credit_eff[i] = w_all_zero ? w_weight[i] : r_credit[i];
      if (w_wcand[i] && (w_credit_eff[i] > w_max_credit)) w_max_credit = w_credit_eff[i];
    end
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_credit_tie[i] = w_wcand[i] && (w_credit_eff[i] == w_max_credit);
    end
  end

  daq_rr_picker #(.NUM_CHANNELS(NUM_CHANNELS), .CHANNEL_WIDTH(CHANNEL_WIDTH)) u_pick_starve (
    .i_mask(w_starved), .i_ptr(r_ptr), .o_found(w_starve_found), .o_index(w_starve_idx));
  daq_rr_picker #(.NUM_CHANNELS(NUM_CHANNELS), .CHANNEL_WIDTH(CHANNEL_WIDTH)) u_pick_prio (
    .i_mask(w_prio_tie), .i_ptr(r_ptr), .o_found(w_prio_found), .o_index(w_prio_idx));
  daq_rr_picker #(.NUM_CHANNELS(NUM_CHANNELS), .CHANNEL_WIDTH(CHANNEL_WIDTH)) u_pick_credit (
    .i_mask(w_credit_tie), .i_ptr(r_ptr), .o_found(w_credit_found), .o_index(w_credit_idx));
  daq_rr_picker #(.NUM_CHANNELS(NUM_CHANNELS), .CHANNEL_WIDTH(CHANNEL_WIDTH)) u_pick_urgent (
    .i_mask(w_urgent), .i_ptr(r_ptr), .o_found(w_urgent_found), .o_index(w_urgent_idx));
  daq_rr_picker #(.NUM_CHANNELS(NUM_CHANNELS), .CHANNEL_WIDTH(CHANNEL_WIDTH)) u_pick_plain (
    .i_mask(w_elig), .i_ptr(r_ptr), .o_found(w_plain_found), .o_index(w_plain_idx));

  // Winner selection: starvation first, then the rule of the current mode.
  always_comb begin
    w_winner       = w_plain_idx;
    w_starve_pick  = 1'b0;
    w_use_weighted = 1'b0;
    if (w_starve_found) begin
      w_winner      = w_starve_idx;
      w_starve_pick = 1'b1;
    end else begin
      case (w_mode)
        ARB_RR: w_winner = w_plain_idx;
        ARB_PRIO: begin
          if (w_prio_found) w_winner = w_prio_idx;
        end
        ARB_WEIGHTED: begin
          if (w_credit_found) w_winner = w_credit_idx;
          w_use_weighted = 1'b1;
        end
        ARB_DYNAMIC: begin
          if (w_urgent_found) begin
            w_winner = w_urgent_idx;
          end else begin
            if (w_credit_found) w_winner = w_credit_idx;
            w_use_weighted = 1'b1;
          end
        end
        default: w_winner = w_plain_idx;
      endcase
    end
  end

  // Credit pool as it stands after this grant: optional reload, then winner decrement.
  always_comb begin
    w_reload    = w_use_weighted && w_all_zero;
    w_decrement = (w_mode == ARB_WEIGHTED) || (w_mode == ARB_DYNAMIC);
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      w_credit_base[i] = w_reload ? w_weight[i] : r_credit[i];
      w_credit_book[i] = w_credit_base[i];
      if (w_decrement && (i == int'(w_winner)) && (w_credit_base[i] != '0)) begin
        w_credit_book[i] = w_credit_base[i] - WEIGHT_WIDTH'(1);
      end
    end
  end

  // Next-state logic: grant when idle and something is eligible; leave HOLD on ack or enable drop.
  always_comb begin
    w_state_next = r_state;
    w_grant_fire = 1'b0;
    w_ack_fire   = 1'b0;
    case (r_state)
      ARB: begin
        if (!i_adc_busy && w_plain_found) begin
          w_grant_fire = 1'b1;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
        if (i_grant_ack) begin
          w_ack_fire   = 1'b1;
          w_state_next = ARB;
        end else if (!i_channel_enable[r_grant_channel]) begin
          w_state_next = ARB;
        end
      end
      default: w_state_next = ARB;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ARB;
    else       r_state <= w_state_next;
  end

  // Grant channel latches on grant; starve flag is a pulse aligned with the rising grant.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant_channel <= '0;
      r_starve_flag   <= 1'b0;
    end else begin
      r_starve_flag <= w_grant_fire && w_starve_pick;
      if (w_grant_fire) r_grant_channel <= w_winner;
    end
  end

  // Pointer and credit bookkeeping is staged at grant and committed on ack, so a
  // withdrawn grant leaves both exactly as they were before it was issued.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr      <= CHANNEL_WIDTH'(NUM_CHANNELS - 1);
      r_ptr_pend <= CHANNEL_WIDTH'(NUM_CHANNELS - 1);
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        r_credit[i]      <= '0;
        r_credit_pend[i] <= '0;
      end
    end else begin
      if (w_grant_fire) begin
        r_ptr_pend <= w_winner;
        for (int i = 0; i < NUM_CHANNELS; i++) r_credit_pend[i] <= w_credit_book[i];
      end
      if (w_ack_fire) begin
        r_ptr <= r_ptr_pend;
        for (int i = 0; i < NUM_CHANNELS; i++) r_credit[i] <= r_credit_pend[i];
      end
    end
  end

  // Aging: waiting eligible channels count up to the limit; ineligible or granted ones clear.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (i_rst || !w_elig[i]) begin
        r_age[i] <= '0;
      end else if ((w_grant_fire && (i == int'(w_winner))) ||
                   ((r_state == HOLD) && (i == int'(r_grant_channel)))) begin
        r_age[i] <= '0;
      end else if (r_age[i] < AGE_WIDTH'(AGE_LIMIT)) begin
        r_age[i] <= r_age[i] + AGE_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_daq_channel_arbiter.sv
// tb/tb_daq_channel_arbiter.sv - randomized and directed bench for daq_channel_arbiter
module tb_daq_channel_arbiter;

  localparam int N   = 16;
  localparam int LIM = 8;

  logic          clk;
  logic          rst;
  logic [1:0]    mode;
  logic [N-1:0]  en, rdy, urg;
  logic [N*4-1:0] prio_flat;
  logic [N*8-1:0] wt_flat;
  logic          busy, ack;
  logic          o_gv, o_sf;
  logic [3:0]    o_gch;

  logic [3:0]    prio [N];
  logic [7:0]    wt   [N];

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  bit m_gv, m_sf;
  int m_gch, m_ptr, sv_ptr;
  int m_age [N];
  int m_cred [N];
  int sv_cred [N];

  int obs_ch [$];
  int obs_sf [$];
  bit obs_prev_gv;

  daq_channel_arbiter #(.NUM_CHANNELS(N), .AGE_LIMIT(LIM)) dut (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_channel_enable(en),
    .i_channel_ready(rdy), .i_urgent_mask(urg), .i_priority_flat(prio_flat),
    .i_weight_flat(wt_flat), .i_adc_busy(busy), .o_grant_valid(o_gv),
    .o_grant_channel(o_gch), .i_grant_ack(ack), .o_starve_flag(o_sf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      prio_flat[i*4 +: 4] = prio[i];
      wt_flat[i*8 +: 8]   = wt[i];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] set, input int ptr);
    for (int k = 1; k <= N; k++) begin
      if (set[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic age_all(input logic [N-1:0] elig, input int skip);
    for (int i = 0; i < N; i++) begin
      if (!elig[i] || i == skip) m_age[i] = 0;
      else if (m_age[i] < LIM)   m_age[i] = m_age[i] + 1;
    end
  endtask

  // Advances the model one clock using the inputs currently applied.
  task automatic model_step();
    logic [N-1:0] elig, starved, set, cand;
    int w, maxp, maxc;
    bit reload, starve, allz;
    elig = rdy & en;
    if (rst) begin
      m_gv = 0; m_sf = 0; m_gch = 0; m_ptr = N - 1; sv_ptr = N - 1;
      for (int i = 0; i < N; i++) begin m_age[i] = 0; m_cred[i] = 0; sv_cred[i] = 0; end
      return;
    end
    m_sf = 0;
    if (!m_gv) begin
      if (!busy && elig != 0) begin
        reload = 0; starve = 0; w = 0;
        starved = '0;
        for (int i = 0; i < N; i++) starved[i] = elig[i] && (m_age[i] >= LIM);
        if (starved != 0) begin
          w = rr_pick(starved, m_ptr); starve = 1;
        end else if (mode == 2'd0) begin
          w = rr_pick(elig, m_ptr);
        end else if (mode == 2'd1) begin
          maxp = -1;
          for (int i = 0; i < N; i++) if (elig[i] && int'(prio[i]) > maxp) maxp = int'(prio[i]);
          set = '0;
          for (int i = 0; i < N; i++) set[i] = elig[i] && (int'(prio[i]) == maxp);
          w = rr_pick(set, m_ptr);
        end else if (mode == 2'd3 && (elig & urg) != 0) begin
          w = rr_pick(elig & urg, m_ptr);
        end else begin
          allz = 1;
          for (int i = 0; i < N; i++) if (elig[i] && m_cred[i] != 0) allz = 0;
          cand = '0;
          for (int i = 0; i < N; i++) cand[i] = elig[i] && (wt[i] != 0);
          if (cand == 0) cand = elig;
          maxc = -1;
          for (int i = 0; i < N; i++)
            if (cand[i] && (allz ? int'(wt[i]) : m_cred[i]) > maxc) maxc = allz ? int'(wt[i]) : m_cred[i];
          set = '0;
          for (int i = 0; i < N; i++) set[i] = cand[i] && ((allz ? int'(wt[i]) : m_cred[i]) == maxc);
          w = rr_pick(set, m_ptr);
          reload = allz;
        end
        age_all(elig, w);
        sv_ptr = m_ptr;
        sv_cred = m_cred;
        if (reload) for (int i = 0; i < N; i++) m_cred[i] = int'(wt[i]);
        if (mode >= 2'd2 && m_cred[w] > 0) m_cred[w] = m_cred[w] - 1;
        m_ptr = w; m_gv = 1; m_gch = w; m_sf = starve;
      end else begin
        age_all(elig, -1);
      end
    end else begin
      age_all(elig, m_gch);
      if (ack) begin
        m_gv = 0;
      end else if (!en[m_gch]) begin
        m_gv = 0; m_ptr = sv_ptr; m_cred = sv_cred;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_eq("gv", o_gv, m_gv);
    check_eq("gch", o_gch, m_gch);
    check_eq("sf", o_sf, m_sf);
    if (o_gv && !obs_prev_gv) begin
      obs_ch.push_back(int'(o_gch));
      obs_sf.push_back(int'(o_sf));
    end
    obs_prev_gv = o_gv;
  endtask

  task automatic run(input int n, input bit auto_ack);
    for (int c = 0; c < n; c++) begin
      ack = auto_ack ? m_gv : 1'b0;
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1; ack = 0; busy = 0; en = '0; rdy = '0; urg = '0;
    tick(); tick();
    rst = 0;
    obs_ch.delete(); obs_sf.delete();
  endtask

  function automatic int logged(input int k);
    return (k < obs_ch.size()) ? obs_ch[k] : -1;
  endfunction

  function automatic int logged_sf(input int k);
    return (k < obs_sf.size()) ? obs_sf[k] : -1;
  endfunction

  int exp_m1 [4]  = '{2, 5, 2, 5};
  int exp_m2 [6]  = '{1, 1, 0, 1, 1, 1};
  int exp_zw [4]  = '{1, 1, 1, 0};
  int exp_m3 [6]  = '{1, 2, 1, 2, 3, 0};
  int exp_m3f [6] = '{0, 0, 0, 0, 1, 1};

  initial begin
    rst = 1; mode = 0; en = '0; rdy = '0; urg = '0; busy = 0; ack = 0; obs_prev_gv = 0;
    for (int i = 0; i < N; i++) begin prio[i] = 4'd0; wt[i] = 8'd0; end

    // Reset state
    do_reset();
    check_eq("rst_gv", o_gv, 0);
    check_eq("rst_gch", o_gch, 0);
    check_eq("rst_sf", o_sf, 0);

    // Mode 0, all channels waiting
    mode = 2'd0; en = 16'hFFFF; rdy = 16'hFFFF;
    run(36, 1);
    for (int k = 0; k <= 16; k++) check_eq($sformatf("m0_g%0d", k), logged(k), k % 16);

    // Mode 1 with a tie between channels 2 and 5
    do_reset();
    mode = 2'd1;
    for (int i = 0; i < N; i++) prio[i] = 4'd3;
    prio[2] = 4'd9; prio[5] = 4'd9;
    en = 16'hFFFF; rdy = 16'h0024;
    run(10, 1);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("m1_g%0d", k), logged(k), exp_m1[k]);
      check_eq($sformatf("m1_sf%0d", k), logged_sf(k), 0);
    end

    // Mode 2 credits
    do_reset();
    mode = 2'd2;
    for (int i = 0; i < N; i++) wt[i] = 8'd0;
    wt[0] = 8'd1; wt[1] = 8'd3;
    en = 16'hFFFF; rdy = 16'h0003;
    run(12, 1);
    for (int k = 0; k < 6; k++) check_eq($sformatf("m2_g%0d", k), logged(k), exp_m2[k]);

    // Mode 2 zero weight
    do_reset();
    mode = 2'd2; wt[0] = 8'd0; wt[1] = 8'd1;
    en = 16'hFFFF; rdy = 16'h0003;
    run(6, 1);
    rdy = 16'h0001;
    run(4, 1);
    for (int k = 0; k < 4; k++) check_eq($sformatf("zw_g%0d", k), logged(k), exp_zw[k]);

    // Mode 3 urgent with aging
    do_reset();
    mode = 2'd3; urg = 16'h0006; en = 16'hFFFF; rdy = 16'h000F;
    run(12, 1);
    for (int k = 0; k < 6; k++) begin
      check_eq($sformatf("m3_g%0d", k), logged(k), exp_m3[k]);
      check_eq($sformatf("m3_sf%0d", k), logged_sf(k), exp_m3f[k]);
    end

    // Withdrawal leaves the pointer untouched
    do_reset();
    mode = 2'd0; en = 16'h0003; rdy = 16'h0003;
    run(1, 0);
    check_eq("wd_hold", o_gv, 1);
    en = 16'h0002;
    run(1, 0);
    check_eq("wd_gv", o_gv, 0);
    en = 16'h0003;
    run(1, 0);
    check_eq("wd_regrant", o_gch, 0);

    // Reset during HOLD
    do_reset();
    mode = 2'd0; en = 16'h0008; rdy = 16'h0008;
    run(1, 0);
    check_eq("rh_gch", o_gch, 3);
    rst = 1;
    run(1, 0);
    check_eq("rh_gv", o_gv, 0);
    check_eq("rh_gch0", o_gch, 0);
    check_eq("rh_sf", o_sf, 0);
    rst = 0;

    // Randomized traffic against the model
    do_reset();
    en = 16'hFFFF;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) begin
        for (int i = 0; i < N; i++) begin
          prio[i] = 4'($urandom_range(0, 15));
          wt[i]   = 8'($urandom_range(0, 5));
        end
      end
      if ($urandom_range(0, 7) == 0) en = 16'($urandom) | 16'($urandom);
      if ($urandom_range(0, 15) == 0) urg = 16'($urandom) & 16'($urandom);
      rdy  = 16'($urandom);
      busy = ($urandom_range(0, 3) == 0);
      ack  = ($urandom_range(0, 1) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/daq_channel_arbiter.md
# daq_channel_arbiter

Parametrised next-generation channel arbiter for the high-speed DAQ controller. Sits between per-channel ready logic and the ADC sequencer, and selects which enabled, ready channel converts next. Supports round-robin, priority, weighted-credit and dynamic urgent modes. Adds per-channel starvation aging and an explicit grant/ack handshake, and is generalised to any channel count.

## Interface

- NUM_CHANNELS, 16: number of channels, 2..64.
- CHANNEL_WIDTH, $clog2(NUM_CHANNELS): width of the channel index.
- PRIO_WIDTH, 4: per-channel priority width.
- WEIGHT_WIDTH, 8: per-channel weight and credit width.
- AGE_LIMIT, 255: wait cycles before a channel is starved; 1..2^16-1.
- clk  in  1  system clock, the single clock domain.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  0 round-robin, 1 priority, 2 weighted, 3 dynamic.
- channel_enable  in  NUM_CHANNELS  per-channel enable mask.
- channel_ready  in  NUM_CHANNELS  per-channel request.
- urgent_mask  in  NUM_CHANNELS  urgent flags, used only in mode 3.
- priority_flat  in  NUM_CHANNELS*PRIO_WIDTH  channel i priority is bits [i*PRIO_WIDTH +: PRIO_WIDTH]; a larger value means higher priority.
- weight_flat  in  NUM_CHANNELS*WEIGHT_WIDTH  channel i weight.
- adc_busy  in  1  blocks new arbitration while high.
- grant_valid  out  1  a grant is held.
- grant_channel  out  CHANNEL_WIDTH  index of the granted channel.
- grant_ack  in  1  consumer accepts the grant.
- starve_flag  out  1  one-cycle pulse when a grant was forced by starvation.

## Operation

- A channel is eligible when channel_ready[i] & channel_enable[i].
- FSM has two states, ARB and HOLD. Reset puts it in ARB.
- **ARB to HOLD:** taken when adc_busy=0 and at least one channel is eligible. On this transition the block registers the winner, sets grant_valid=1, and applies the bookkeeping below.
- **HOLD to ARB:** taken on grant_ack=1, or when channel_enable[grant_channel] drops.
  - A drop of enable is a withdrawal: grant_valid returns to 0 and no bookkeeping is applied.
  - A drop of channel_ready while in HOLD does not withdraw the grant.
- **Bookkeeping on grant:**
  - the round-robin pointer is set to the winner;
  - the winner's age counter is cleared;
  - in modes 2 and 3, the winner's credit is decremented when nonzero.
- **Winner selection, first rule that applies:**
  1. Starvation override: if any eligible channel has age ≥ AGE_LIMIT, pick among those channels by round-robin. Pulse starve_flag.
  2. Mode 0: first eligible channel at or after pointer+1, wrapping modulo NUM_CHANNELS.
  3. Mode 1: highest priority value wins. Ties are broken by round-robin from pointer+1.
  4. Mode 2: eligible channel with the largest credit; ties broken by round-robin.
     - If every eligible channel has credit 0, reload all credits from weight_flat in that cycle, then choose.
     - A channel whose weight is 0 wins only when it is the sole eligible channel.
  5. Mode 3: if any eligible channel is urgent, round-robin among the urgent eligible channels. Otherwise apply mode 2.
- **Aging:**
  - Each cycle a channel is eligible and not being granted, its age increments.
  - Age saturates at AGE_LIMIT.
  - Age clears when the channel is not eligible.
- All comparisons are unsigned. Credit arithmetic never wraps below 0.

## Timing

- **Reset values:** grant_valid=0, grant_channel=0, starve_flag=0, pointer=NUM_CHANNELS-1 (so channel 0 wins first in round-robin), ages=0, credits=0.
- **Latency:** inputs sampled in cycle N produce grant_valid=1 in cycle N+1.
- grant_channel is stable for the whole time grant_valid=1.
- grant_ack is only honoured while grant_valid=1.
- **After ack:** ack in cycle N gives grant_valid=0 in N+1. The earliest next grant is N+2, so there is at least one idle cycle between grants.
- Changes to mode, priority, weight or urgent inputs during HOLD take effect at the next ARB decision.
- Reset has priority over everything. Asserting rst mid-HOLD returns all outputs to their reset values on the next edge.
- Simultaneous ack and enable drop in the same cycle is treated as an ack, so bookkeeping already applied stands.
- starve_flag is high in the same cycle that grant_valid first rises.

## Structure

- Package daq_arb_pkg holds:
  - arb_mode_e: ARB_RR=0, ARB_PRIO=1, ARB_WEIGHTED=2, ARB_DYNAMIC=3;
  - arb_state_e: ARB, HOLD;
  - a function to compute the default channel-index width.
- One sub-module, daq_rr_picker: a combinational rotating first-one finder over a NUM_CHANNELS mask, starting from pointer+1. It outputs found and index. The arbiter instantiates it once per candidate mask (starved, priority-tie, credit-tie, urgent, plain).

## Test plan

- **Mode 0 with all channels waiting:** ready=enable=16'hFFFF, ack every grant one cycle later. Required grant sequence is 0,1,...,15,0, with grant_valid low for one cycle between grants.
- **Mode 1 with a tie:** priorities ch2=ch5=9 and all others 3, ready=16'h0024. Grants must alternate 2,5,2,5. Channel 5 must never starve.
- **Mode 2 credits:** weights ch0=1, ch1=3, ready=16'h0003. The first 4 grants must be 1,1,0,1 (the first tie goes by round-robin), followed by a reload.
- **Mode 2 zero weight:** weights ch0=0, ch1=1. Channel 0 is granted only after channel 1's ready is deasserted.
- **Mode 3 urgent and aging:** urgent_mask=16'h0006, ready=16'h000F, AGE_LIMIT=8.
  - Grants must come only from channels 1 and 2 until channel 0's age reaches 8.
  - Channel 0 is then granted with starve_flag=1.
- **Withdrawal and reset:**
  - Drop channel_enable of the granted channel during HOLD: grant_valid=0 next cycle, and the pointer is unchanged.
  - Assert rst during HOLD: all outputs return to 0 on the next edge.
